// File: rtl/adc_responder.sv
// LTC2308-style SPI ADC responder: captures the 6-bit config word on SDI
// and returns the 12-bit sample of the previously configured channel on SDO.
module adc_responder #(
   parameter int CONV_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ADC_CONVST,
   input  logic        ADC_SCK,
   input  logic        ADC_SDI,
   input  logic [95:0] ch_data,
   output logic        ADC_SDO,
   output logic [5:0]  cfg_word,
   output logic        busy,
   output logic        frame_done,
   output logic        sck_err
);

   localparam int CW = $clog2(CONV_CYCLES + 2);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      SHIFT
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [2:0]     conv_q;
   logic [2:0]     sck_q;
   logic [1:0]     sdi_q;
   logic           conv_rise;
   logic           sck_rise;
   logic           sck_fall;
   logic           sdi_s;
   logic [2:0]     chan;
   logic [CW-1:0]  conv_cnt;
   logic [11:0]    res_sr;
   logic [4:0]     sdi_sr;
   logic [2:0]     rx_cnt;
   logic [3:0]     tx_cnt;

   // Two sync flops per pin, third flop only for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conv_q <= '0;
         sck_q  <= '0;
         sdi_q  <= '0;
      end else begin
         conv_q <= {conv_q[1:0], ADC_CONVST};
         sck_q  <= {sck_q[1:0], ADC_SCK};
         sdi_q  <= {sdi_q[0], ADC_SDI};
      end
   end

   assign conv_rise = conv_q[1] & ~conv_q[2];
   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] & sck_q[2];
   assign sdi_s     = sdi_q[1];
   assign chan      = {cfg_word[3:2], cfg_word[4]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = IDLE;
         CONV:  if (conv_cnt == '0) state_nx = SHIFT;
         SHIFT: if (sck_fall && tx_cnt == 4'd11) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // A new conversion start overrides everything, including SCK edges
      if (conv_rise) state_nx = (CONV_CYCLES == 0) ? SHIFT : CONV;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conv_cnt   <= '0;
         res_sr     <= '0;
         sdi_sr     <= '0;
         rx_cnt     <= '0;
         tx_cnt     <= '0;
         cfg_word   <= 6'b100010;
         frame_done <= 1'b0;
         sck_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (conv_rise) begin
            res_sr   <= ch_data[12*chan +: 12];
            conv_cnt <= CW'(CONV_CYCLES - 1);
            sdi_sr   <= '0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
         end else begin
            unique case (state)
               IDLE: ;
               CONV: begin
                  if (sck_rise || sck_fall) sck_err <= 1'b1;
                  if (conv_cnt != '0) conv_cnt <= conv_cnt - 1'b1;
               end
               SHIFT: begin
                  if (sck_rise && rx_cnt != 3'd6) begin
                     sdi_sr <= {sdi_sr[3:0], sdi_s};
                     rx_cnt <= rx_cnt + 3'd1;
                     if (rx_cnt == 3'd5) cfg_word <= {sdi_sr, sdi_s};
                  end
                  if (sck_fall) begin
                     res_sr <= {res_sr[10:0], 1'b0};
                     tx_cnt <= tx_cnt + 4'd1;
                     if (tx_cnt == 4'd11) frame_done <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ADC_SDO = (state == SHIFT) & res_sr[11];
   assign busy    = (state == CONV);

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: two instances (CONV_CYCLES 0 and 16) driven
// initiator-style, checked against a transaction-level model.
module tb_adc_responder;

   localparam int H = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        convst [2];
   logic        sck    [2];
   logic        sdi    [2];
   logic        sdo    [2];
   logic        busy   [2];
   logic        fd     [2];
   logic        err    [2];
   logic [5:0]  cfg    [2];
   logic [95:0] ch_data;

   int          fd_cnt [2] = '{0, 0};
   logic [5:0]  m_cfg  [2];
   logic        m_err  [2];
   int          m_fd   [2];
   logic [11:0] m_smp  [2];
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   adc_responder #(.CONV_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .ADC_CONVST(convst[0]), .ADC_SCK(sck[0]), .ADC_SDI(sdi[0]),
      .ch_data(ch_data), .ADC_SDO(sdo[0]), .cfg_word(cfg[0]),
      .busy(busy[0]), .frame_done(fd[0]), .sck_err(err[0])
   );

   adc_responder #(.CONV_CYCLES(16)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .ADC_CONVST(convst[1]), .ADC_SCK(sck[1]), .ADC_SDI(sdi[1]),
      .ch_data(ch_data), .ADC_SDO(sdo[1]), .cfg_word(cfg[1]),
      .busy(busy[1]), .frame_done(fd[1]), .sck_err(err[1])
   );

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         if (fd[d] === 1'b1) fd_cnt[d] <= fd_cnt[d] + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic logic [11:0] m_sample(input logic [5:0] c);
      int ch;
      ch = c[4] + 2 * c[2] + 4 * c[3];
      return 12'(ch_data >> (12 * ch));
   endfunction

   task automatic conv_start(input int d, input bit toggles);
      m_smp[d] = m_sample(m_cfg[d]);
      convst[d] = 1'b1;
      clks(3);
      convst[d] = 1'b0;
      if (toggles) begin
         for (int i = 0; i < 4; i++) begin
            sck[d] = ~sck[d];
            clks(3);
         end
         m_err[d] = 1'b1;
      end else begin
         clks(5);
      end
      #1;
      chk($sformatf("busy d%0d", d), busy[d], d == 1);
      clks(20);
      #1;
      chk($sformatf("sck_err d%0d", d), err[d], m_err[d]);
   endtask

   task automatic shift(input int d, input int n, input logic [5:0] c,
                        output logic [11:0] word);
      logic e;
      word = '0;
      for (int i = 0; i < n; i++) begin
         sdi[d] = (i < 6) ? c[5-i] : 1'($urandom);
         clks(H);
         #1;
         e = (i < 12) ? m_smp[d][11-i] : 1'b0;
         chk($sformatf("sdo d%0d bit%0d", d, i), sdo[d], e);
         if (i < 12) word = {word[10:0], sdo[d]};
         sck[d] = 1'b1;
         clks(H);
         sck[d] = 1'b0;
      end
      clks(6);
      #1;
      if (n >= 6) m_cfg[d] = c;
      if (n >= 12) m_fd[d]++;
      chk($sformatf("cfg_word d%0d", d), cfg[d], m_cfg[d]);
      chk($sformatf("frame_done count d%0d", d), fd_cnt[d], m_fd[d]);
      if (n >= 12) chk($sformatf("sdo idle d%0d", d), sdo[d], 1'b0);
   endtask

   task automatic check_reset_state();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst sdo d%0d", d), sdo[d], 1'b0);
         chk($sformatf("rst cfg d%0d", d), cfg[d], 6'b100010);
         chk($sformatf("rst busy d%0d", d), busy[d], 1'b0);
         chk($sformatf("rst err d%0d", d), err[d], 1'b0);
         chk($sformatf("rst fd d%0d", d), fd[d], 1'b0);
      end
   endtask

   initial begin
      logic [11:0] w;
      logic [5:0]  c;
      int          d;
      int          n;
      int          nlist [8] = '{3, 5, 6, 8, 12, 12, 13, 14};

      for (int i = 0; i < 2; i++) begin
         convst[i] = 1'b0;
         sck[i]    = 1'b0;
         sdi[i]    = 1'b0;
         m_cfg[i]  = 6'b100010;
         m_err[i]  = 1'b0;
         m_fd[i]   = 0;
         m_smp[i]  = '0;
      end
      ch_data = '0;
      reset_n = 1'b0;
      clks(4);
      #1;
      check_reset_state();
      reset_n = 1'b1;
      clks(4);

      ch_data = {$urandom, $urandom, $urandom};
      ch_data[11:0]  = 12'hA5C;
      ch_data[71:60] = 12'h3F1;
      conv_start(0, 1'b0);
      shift(0, 12, 6'b111010, w);
      chk("frame1 word", w, 12'hA5C);
      chk("frame1 cfg", cfg[0], 6'b111010);
      conv_start(0, 1'b0);
      ch_data = {$urandom, $urandom, $urandom};
      shift(0, 12, 6'b100010, w);
      chk("frame2 word", w, 12'h3F1);

      ch_data = {$urandom, $urandom, $urandom};
      conv_start(1, 1'b1);
      shift(1, 12, 6'b110110, w);
      conv_start(1, 1'b0);
      shift(1, 12, 6'($urandom), w);
      chk("sck_err sticky", err[1], 1'b1);

      conv_start(0, 1'b0);
      shift(0, 5, 6'($urandom), w);
      conv_start(0, 1'b0);
      shift(0, 12, 6'($urandom), w);

      conv_start(0, 1'b0);
      shift(0, 14, 6'($urandom), w);

      for (int k = 0; k < 24; k++) begin
         d = $urandom_range(0, 1);
         ch_data = {$urandom, $urandom, $urandom};
         c = 6'($urandom);
         n = nlist[$urandom_range(0, 7)];
         conv_start(d, (d == 1) && ($urandom_range(0, 3) == 0));
         ch_data = {$urandom, $urandom, $urandom};
         shift(d, n, c, w);
      end

      conv_start(0, 1'b0);
      shift(0, 3, 6'($urandom), w);
      reset_n = 1'b0;
      clks(2);
      #1;
      check_reset_state();
      for (int i = 0; i < 2; i++) begin
         m_cfg[i] = 6'b100010;
         m_err[i] = 1'b0;
      end
      reset_n = 1'b1;
      clks(4);
      for (int i = 0; i < 2; i++) begin
         ch_data = {$urandom, $urandom, $urandom};
         conv_start(i, 1'b0);
         shift(i, 12, 6'($urandom), w);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
